// File: rtl/ldm_stm_sequencer_pkg.sv
// ldm_stm_sequencer_pkg
// Shared definitions for the LDM/STM block-transfer sequencer.
//   state_e    : sequencer FSM states (also exported on the debug port)
//   WORD_BYTES : address step between consecutive transferred registers
//   REG_PC     : register number of the program counter
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_XFER   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  REG_PC     = 4'd15;

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// ldm_stm_sequencer_if
// Register-file and memory-port signals owned by the sequencer during a
// block transfer.
//   Register file: rf_read_num -> rf_read_data (combinational read),
//                  rf_write_en / rf_write_num / rf_write_data (write strobe).
//   Memory: valid/ready-style handshake. mem_req is the request (valid) and
//           mem_ack the completion (ready); a transfer completes in the
//           cycle where both are high. While mem_req is high and mem_ack low,
//           mem_we, mem_addr, mem_wdata and rf_read_num stay stable.
//           mem_rdata is meaningful only in the mem_ack cycle of a load.
//   master : the sequencer; slave : the register file / memory side.
interface ldm_stm_sequencer_if;
  logic [3:0]  rf_read_num;
  logic [31:0] rf_read_data;
  logic        rf_write_en;
  logic [3:0]  rf_write_num;
  logic [31:0] rf_write_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output rf_read_num, rf_write_en, rf_write_num, rf_write_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  rf_read_data, mem_rdata, mem_ack
  );

  modport slave (
    input  rf_read_num, rf_write_en, rf_write_num, rf_write_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output rf_read_data, mem_rdata, mem_ack
  );
endinterface

// File: rtl/ldm_stm_sequencer_lsb_find16.sv
// lsb_find16
// Combinational lowest-set-bit finder over a 16-bit vector.
//   vec_i : input vector
//   idx_o : index of the lowest set bit (0 when vec_i is zero)
//   any_o : 1 when any bit of vec_i is set
module lsb_find16 (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx_o = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 4'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
// Walks an LDM/STM register list one register per memory transfer, lowest
// register at the lowest address, then optionally writes the final address
// back to the base register.
// Ports:
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   start            : begin a transfer (sampled only when idle)
//   reg_list, base, base_reg, load, up, pre, wback : transfer descriptor
//   busy, done       : busy in every non-idle state, done pulses in FINISH
//   dbg_state        : current FSM state
//   bus              : register-file and memory port (master side)
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           reg_list,
  input  logic [31:0]           base,
  input  logic [3:0]            base_reg,
  input  logic                  load,
  input  logic                  up,
  input  logic                  pre,
  input  logic                  wback,
  output logic                  busy,
  output logic                  done,
  output state_e                dbg_state,
  ldm_stm_sequencer_if.master   bus
);

  state_e      state_q, state_d;
  logic [15:0] list_q;
  logic [15:0] pending_q, pending_d;
  logic [31:0] base_q;
  logic [3:0]  base_reg_q;
  logic        load_q, up_q, pre_q, wback_q;
  logic [31:0] addr_q, addr_d;
  logic [31:0] final_q, final_d;

  logic        capture;
  logic [3:0]  cur_reg;
  logic        cur_any;
  logic [4:0]  cnt;
  logic [31:0] span;
  logic        base_loaded;

  lsb_find16 u_lsb (
    .vec_i (pending_q),
    .idx_o (cur_reg),
    .any_o (cur_any)
  );

  assign capture     = (state_q == ST_IDLE) && start;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;
  // A loaded base register keeps its loaded value instead of the writeback.
  assign base_loaded = load_q && list_q[base_reg_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      list_q     <= '0;
      pending_q  <= '0;
      base_q     <= '0;
      base_reg_q <= '0;
      load_q     <= 1'b0;
      up_q       <= 1'b0;
      pre_q      <= 1'b0;
      wback_q    <= 1'b0;
      addr_q     <= '0;
      final_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      final_q   <= final_d;
      if (capture) begin
        list_q     <= reg_list;
        base_q     <= base & ~32'h3;
        base_reg_q <= base_reg;
        load_q     <= load;
        up_q       <= up;
        pre_q      <= pre;
        wback_q    <= wback;
      end
    end
  end

  // Popcount and block span, only consumed in SETUP.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, list_q[i]};
    end
    span = 32'(cnt) * WORD_BYTES;
  end

  always_comb begin
    state_d           = state_q;
    pending_d         = pending_q;
    addr_d            = addr_q;
    final_d           = final_q;
    done              = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.rf_read_num   = '0;
    bus.rf_write_en   = 1'b0;
    bus.rf_write_num  = '0;
    bus.rf_write_data = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pending_d = reg_list;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        // Lowest register always sits at the lowest address, so decrementing
        // modes start at the bottom of the block and walk upwards.
        if (up_q) addr_d = pre_q ? base_q + 32'(WORD_BYTES) : base_q;
        else      addr_d = pre_q ? base_q - span : base_q - span + 32'(WORD_BYTES);
        final_d = up_q ? base_q + span : base_q - span;
        state_d = (cnt == 5'd0) ? ST_FINISH : ST_XFER;
      end

      ST_XFER: begin
        bus.mem_req     = cur_any;
        bus.mem_we      = !load_q;
        bus.mem_addr    = addr_q;
        bus.rf_read_num = cur_reg;
        bus.mem_wdata   = bus.rf_read_data;
        if (bus.mem_ack) begin
          if (load_q) begin
            bus.rf_write_en   = 1'b1;
            bus.rf_write_num  = cur_reg;
            bus.rf_write_data = bus.mem_rdata;
          end
          pending_d = pending_q & ~(16'd1 << cur_reg);
          addr_d    = addr_q + 32'(WORD_BYTES);
          if (pending_d == 16'd0) state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        done = 1'b1;
        if (wback_q && (list_q != 16'd0) && !base_loaded) begin
          bus.rf_write_en   = 1'b1;
          bus.rf_write_num  = base_reg_q;
          bus.rf_write_data = final_q;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;
  import ldm_stm_sequencer_pkg::*;

  localparam int EW = 71;
  localparam logic [1:0] EV_MEM  = 2'd1;
  localparam logic [1:0] EV_RF   = 2'd2;
  localparam logic [1:0] EV_DONE = 2'd3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic        start = 1'b0;
  logic [15:0] reg_list = '0;
  logic [31:0] base = '0;
  logic [3:0]  base_reg = '0;
  logic        load = 1'b0, up = 1'b0, pre = 1'b0, wback = 1'b0;
  logic        busy, done;
  state_e      dbg_state;

  ldm_stm_sequencer_if bus ();

  ldm_stm_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .reg_list  (reg_list),
    .base      (base),
    .base_reg  (base_reg),
    .load      (load),
    .up        (up),
    .pre       (pre),
    .wback     (wback),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // Register file model: R[i] = A000_000i, read combinationally.
  logic [31:0] rf_model [16];
  initial for (int i = 0; i < 16; i++) rf_model[i] = 32'hA000_0000 | 32'(i);
  assign bus.rf_read_data = rf_model[bus.rf_read_num];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  int k_start = 0;

  function automatic logic [EW-1:0] mk_ev(input logic [1:0] kind, input logic we,
                                          input logic [3:0] num, input logic [31:0] a,
                                          input logic [31:0] d);
    return {kind, we, num, a, d};
  endfunction

  task automatic push_mem(input logic we, input logic [3:0] num, input logic [31:0] a,
                          input logic [31:0] d);
    exp_q.push_back(mk_ev(EV_MEM, we, num, a, d));
  endtask

  task automatic push_rf(input logic [3:0] num, input logic [31:0] d);
    exp_q.push_back(mk_ev(EV_RF, 1'b0, num, 32'd0, d));
  endtask

  task automatic push_done(input int off);
    exp_q.push_back(mk_ev(EV_DONE, 1'b0, 4'd0, 32'(off), 32'd0));
  endtask

  task automatic score(input string name, input logic [EW-1:0] act);
    logic [EW-1:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event %h, required none", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", name, act, e);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_zero(input string name);
    logic [140:0] outs;
    outs = {busy, done, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
            bus.rf_write_en, bus.rf_write_num, bus.rf_write_data, bus.rf_read_num,
            4'(dbg_state)};
    n_vec++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs %h required all zero", name, outs);
    end
  endtask

  // ---------------- memory responder ----------------
  int wait_cfg   = 0;
  bit ack_always = 1'b0;
  initial begin
    int w;
    w = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clock);
      #1;
      bus.mem_ack   = ack_always;
      bus.mem_rdata = 32'hDEAD_BEEF;
      if (bus.mem_req) begin
        if (w < wait_cfg) begin
          w++;
        end else begin
          w = 0;
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_addr ^ 32'h5A5A_0000;
        end
      end else begin
        w = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit          prev_wait;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_num;
    prev_wait = 1'b0;
    h_addr = '0; h_wdata = '0; h_num = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          n_vec++;
          if (!bus.mem_req || bus.mem_addr !== h_addr || bus.mem_wdata !== h_wdata ||
              bus.rf_read_num !== h_num) begin
            n_fail++;
            $display("FAIL hold: req=%0b addr=%h wdata=%h num=%0d required addr=%h wdata=%h num=%0d",
                     bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.rf_read_num,
                     h_addr, h_wdata, h_num);
          end
        end
        if (bus.mem_req && bus.mem_ack)
          score("mem", mk_ev(EV_MEM, bus.mem_we, bus.rf_read_num, bus.mem_addr,
                             bus.mem_we ? bus.mem_wdata : bus.mem_rdata));
        if (bus.rf_write_en)
          score("rf", mk_ev(EV_RF, 1'b0, bus.rf_write_num, 32'd0, bus.rf_write_data));
        if (done)
          score("done", mk_ev(EV_DONE, 1'b0, 4'd0, 32'(cyc - k_start), 32'd0));
        prev_wait = bus.mem_req && !bus.mem_ack;
        h_addr  = bus.mem_addr;
        h_wdata = bus.mem_wdata;
        h_num   = bus.rf_read_num;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [15:0] l, input logic [31:0] b, input logic [3:0] br,
                       input logic ld, input logic u, input logic p, input logic wb);
    @(negedge clock);
    reg_list = l; base = b; base_reg = br;
    load = ld; up = u; pre = p; wback = wb;
    start = 1'b1;
    k_start = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int busy_off);
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (busy) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, t);
    end else begin
      check({name, "_busy_fall"}, 32'(cyc - k_start), 32'(busy_off));
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run(input string name, input logic [15:0] l, input logic [31:0] b,
                     input logic [3:0] br, input logic ld, input logic u, input logic p,
                     input logic wb, input int waits, input int done_off, input bit restart);
    wait_cfg = waits;
    issue(l, b, br, ld, u, p, wb);
    if (restart) begin
      // Second start while busy must be ignored.
      start = 1'b1;
      reg_list = 16'hFFFF;
      @(negedge clock);
      start = 1'b0;
    end
    wait_idle(name, done_off + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #2;
    check_zero("reset_state");
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    @(negedge clock);
    check_zero("idle_after_reset");

    // STMIA R0-R3, base 0x100, base R2 in list: stores original R2, writeback 0x110.
    push_mem(1'b1, 4'd0, 32'h100, 32'hA000_0000);
    push_mem(1'b1, 4'd1, 32'h104, 32'hA000_0001);
    push_mem(1'b1, 4'd2, 32'h108, 32'hA000_0002);
    push_mem(1'b1, 4'd3, 32'h10C, 32'hA000_0003);
    push_rf(4'd2, 32'h110);
    push_done(6);
    run("stmia", 16'h000F, 32'h100, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 0, 6, 1'b0);

    // LDMDB R0,R15 from 0x200 into base R13, with an ignored start while busy.
    push_mem(1'b0, 4'd0,  32'h1F8, 32'h5A5A_01F8);
    push_rf(4'd0, 32'h5A5A_01F8);
    push_mem(1'b0, 4'd15, 32'h1FC, 32'h5A5A_01FC);
    push_rf(4'd15, 32'h5A5A_01FC);
    push_rf(4'd13, 32'h1F8);
    push_done(4);
    run("ldmdb", 16'h8001, 32'h200, 4'd13, 1'b1, 1'b0, 1'b1, 1'b1, 0, 4, 1'b1);

    // LDMIB R1,R2 from 0x40 with two wait cycles per transfer, no writeback.
    push_mem(1'b0, 4'd1, 32'h44, 32'h5A5A_0044);
    push_rf(4'd1, 32'h5A5A_0044);
    push_mem(1'b0, 4'd2, 32'h48, 32'h5A5A_0048);
    push_rf(4'd2, 32'h5A5A_0048);
    push_done(8);
    run("ldmib_wait", 16'h0006, 32'h40, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2, 8, 1'b0);

    // Empty list with writeback and mem_ack stuck high: only done.
    ack_always = 1'b1;
    push_done(2);
    run("empty", 16'h0000, 32'h500, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 2, 1'b0);
    ack_always = 1'b0;

    // LDMIA with base R3 in the list: loaded value wins, no writeback.
    push_mem(1'b0, 4'd3, 32'h80, 32'h5A5A_0080);
    push_rf(4'd3, 32'h5A5A_0080);
    push_done(3);
    run("ldmia_base", 16'h0008, 32'h80, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 0, 3, 1'b0);

    // STMDA R0,R2 from unaligned base 0x302 (treated as 0x300), writeback 0x2F8.
    push_mem(1'b1, 4'd0, 32'h2FC, 32'hA000_0000);
    push_mem(1'b1, 4'd2, 32'h300, 32'hA000_0002);
    push_rf(4'd6, 32'h2F8);
    push_done(4);
    run("stmda", 16'h0005, 32'h302, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0);

    // Reset after the first store of a four-register STM.
    wait_cfg = 0;
    push_mem(1'b1, 4'd4, 32'h600, 32'hA000_0004);
    issue(16'h00F0, 32'h600, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    #1 check_zero("reset_mid");
    repeat (2) @(negedge clock);
    check_zero("reset_hold");
    @(posedge clock);
    #3 reset = 1'b0;
    check("reset_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    check("reset_idle_busy", {31'd0, busy}, 32'd0);

    // Normal LDMIA after the aborted transfer.
    push_mem(1'b0, 4'd0, 32'h700, 32'h5A5A_0700);
    push_rf(4'd0, 32'h5A5A_0700);
    push_mem(1'b0, 4'd1, 32'h704, 32'h5A5A_0704);
    push_rf(4'd1, 32'h5A5A_0704);
    push_rf(4'd5, 32'h708);
    push_done(4);
    run("ldmia_after_reset", 16'h0003, 32'h700, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4, 1'b0);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Sequencer for ARM7TDMI block data transfers (LDM/STM). It walks a 16-bit register list, drives the register file's read and write ports and a word-wide memory request/acknowledge interface one register per transfer, then optionally writes the updated base back. It sits between the decode stage and the register file and memory port, and owns both for the duration of a block transfer.

## Interface
- No parameters. Data width 32, register count 16, fixed.
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin transfer; sampled only in IDLE
- reg_list  in  16  bit i set = transfer R[i]
- base  in  32  base address value, latched at start
- base_reg  in  4  base register number, latched at start
- load  in  1  1 = LDM (mem→reg), 0 = STM (reg→mem)
- up  in  1  1 = increment, 0 = decrement
- pre  in  1  1 = pre-index (IB/DB), 0 = post (IA/DA)
- wback  in  1  write final address to base_reg
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse in FINISH
- rf_read_num  out  4  register file read port 1 select
- rf_read_data  in  32  combinational read data
- rf_write_en  out  1  register write strobe
- rf_write_num  out  4  register write select
- rf_write_data  out  32  register write data
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  32  word address (bits 1:0 always 0)
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  transfer complete this cycle

## Operation
- FSM: IDLE → SETUP → XFER → FINISH → IDLE.
- IDLE: start latches all inputs (base[1:0] forced to 0) → SETUP. start while busy is ignored.
- SETUP: n = popcount(reg_list). First address: IA base, IB base+4, DA base−4n+4, DB base−4n. Final base: up ? base+4n : base−4n (mod 2^32). n = 0 → FINISH directly; no transfers, no writeback.
- XFER: current register = lowest set bit of pending list; lowest register always at lowest address. mem_req=1, mem_addr=current address, mem_we=!load, rf_read_num=current register, mem_wdata=rf_read_data.
- On mem_ack in XFER: LDM asserts rf_write_en with rf_write_num=current register and rf_write_data=mem_rdata (combinational from ack); clear pending bit; address += 4. Pending empty → FINISH.
- FINISH: done=1. If wback and !(load and base_reg in list), rf_write_en=1, rf_write_num=base_reg, rf_write_data=final base. Loaded base value wins over writeback. STM with base in list stores the original base value (no writeback before FINISH).
- Outputs not named as active are 0 outside their state.

## Timing
- Reset values: busy 0, done 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rf_write_en 0, rf_write_num 0, rf_write_data 0, rf_read_num 0; state IDLE, latched registers 0.
- start sampled at edge k: SETUP in cycle k+1, first mem_req in k+2.
- Zero-wait memory: one transfer per cycle; done in cycle k+2+n; busy falls in k+3+n. n = 0: done in k+2.
- Each wait cycle (mem_req high, mem_ack low) extends by one; address, data and register select held stable.
- mem_ack outside XFER is ignored.
- Reset mid-transfer: immediate IDLE, all outputs 0, no register write, no writeback, no done.

## Structure
- Shared package: FSM state enum (IDLE, SETUP, XFER, FINISH), WORD_BYTES = 4, REG_PC = 4'd15.
- Sub-module lsb_find16: combinational lowest-set-bit index plus any-set flag over 16 bits; popcount inline in SETUP.

## Test plan
- STMIA list 0x000F, base 0x100, wback: stores R0..R3 at 0x100, 0x104, 0x108, 0x10C; base_reg ← 0x110; done at k+6.
- LDMDB list 0x8001, base 0x200, wback: reads 0x1F8→R0, 0x1FC→R15; base_reg ← 0x1F8.
- LDMIB list 0x0006, base 0x40, two wait cycles per ack: addresses 0x44, 0x48 held stable through waits; R1, R2 written only on ack cycles.
- Empty list, wback: no mem_req, no rf_write_en, done at k+2.
- LDMIA base_reg=3, list 0x0008, wback: R3 = loaded value, no writeback write in FINISH.
- Reset asserted after first ack of 4-register STM: outputs 0 immediately, no further stores, no done; next start runs normally.
